decodificador_minutos_bcd: RTL and testbench

DECODIFICADOR_MINUTOS_BCD -- requirements
Module: decodificador_minutos_bcd

---
 rtl/decodificador_minutos_bcd.sv | 129 ++++++++++++
 tb/tb_decodificador_minutos_bcd.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decodificador_minutos_bcd.sv
// Converts a packed BCD minutes byte from the RTC into a binary minute counter.
// Optional auto-increment with hour carry is enabled by defining DECMIN_AUTOINC_EN.
//
// state     | meaning
// ESPERA    | idle, accepts a dato_valido strobe
// VALIDA    | captured byte being checked for legal BCD nibbles
// CONVIERTE | BCD converted to binary, checked against MOD_CUENTA
// CARGA     | converted value has been loaded into minutos
module decodificador_minutos_bcd #(
    parameter int MOD_CUENTA = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] datos_MM_in,
    input  logic       dato_valido,
    input  logic       incremento,
    output logic [5:0] minutos,
    output logic       ack,
    output logic       error_bcd,
    output logic       ocupado,
    output logic       acarreo_HH
);

    typedef enum logic [1:0] {ESPERA, VALIDA, CONVIERTE, CARGA} estado_t;

    estado_t    estado;
    logic [7:0] dato_reg;
    logic [6:0] decenas;
    logic [6:0] valor;
    logic       en_rango;

    function automatic logic bcd_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    // tens*10 as tens*8 + tens*2
    assign decenas  = {3'b000, dato_reg[7:4]};
    assign valor    = (decenas << 3) + (decenas << 1) + {3'b000, dato_reg[3:0]};
    assign en_rango = (valor < 7'(MOD_CUENTA));

`ifdef DECMIN_AUTOINC_EN
    localparam logic [5:0] MIN_MAX = 6'(MOD_CUENTA - 1);
    logic acarreo_r;
    logic inc_permitido;

    // an increment coinciding with the load edge or the CARGA cycle is dropped
    assign inc_permitido = incremento && (estado != CARGA) &&
                           !((estado == CONVIERTE) && en_rango);
    assign acarreo_HH    = acarreo_r;
`else
    logic unused_incremento;
    assign unused_incremento = incremento;
    assign acarreo_HH        = 1'b0;
`endif

    // ack/error_bcd/ocupado are decided one edge early so they are visible
    // in the same cycle as the state they describe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado    <= ESPERA;
            dato_reg  <= 8'h00;
            minutos   <= 6'd0;
            ack       <= 1'b0;
            error_bcd <= 1'b0;
            ocupado   <= 1'b0;
`ifdef DECMIN_AUTOINC_EN
            acarreo_r <= 1'b0;
`endif
        end else begin
            ack <= 1'b0;
`ifdef DECMIN_AUTOINC_EN
            acarreo_r <= 1'b0;
            if (inc_permitido) begin
                if (minutos == MIN_MAX) begin
                    minutos   <= 6'd0;
                    acarreo_r <= 1'b1;
                end else begin
                    minutos <= minutos + 6'd1;
                end
            end
`endif
            case (estado)
                ESPERA: begin
                    if (dato_valido) begin
                        dato_reg <= datos_MM_in;
                        estado   <= VALIDA;
                        ocupado  <= 1'b1;
                        if (!bcd_ok(datos_MM_in)) begin
                            ack       <= 1'b1;
                            error_bcd <= 1'b1;
                        end
                    end
                end
                VALIDA: begin
                    if (!bcd_ok(dato_reg)) begin
                        estado  <= ESPERA;
                        ocupado <= 1'b0;
                    end else begin
                        estado <= CONVIERTE;
                        if (!en_rango) begin
                            ack       <= 1'b1;
                            error_bcd <= 1'b1;
                        end
                    end
                end
                CONVIERTE: begin
                    if (!en_rango) begin
                        estado  <= ESPERA;
                        ocupado <= 1'b0;
                    end else begin
                        estado    <= CARGA;
                        minutos   <= valor[5:0];
                        ack       <= 1'b1;
                        error_bcd <= 1'b0;
                    end
                end
                CARGA: begin
                    estado  <= ESPERA;
                    ocupado <= 1'b0;
                end
                default: begin
                    estado  <= ESPERA;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decodificador_minutos_bcd.sv
// Directed bench for decodificador_minutos_bcd (default MOD_CUENTA=60).
// Expectations follow DECMIN_AUTOINC_EN when the bench is built with it defined.
module tb_decodificador_minutos_bcd;

    logic       clk;
    logic       reset;
    logic [7:0] datos_MM_in;
    logic       dato_valido;
    logic       incremento;
    logic [5:0] minutos;
    logic       ack;
    logic       error_bcd;
    logic       ocupado;
    logic       acarreo_HH;

    int n_cmp = 0;
    int n_err = 0;

    decodificador_minutos_bcd dut (
        .clk        (clk),
        .reset      (reset),
        .datos_MM_in(datos_MM_in),
        .dato_valido(dato_valido),
        .incremento (incremento),
        .minutos    (minutos),
        .ack        (ack),
        .error_bcd  (error_bcd),
        .ocupado    (ocupado),
        .acarreo_HH (acarreo_HH)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // strobe in cycle 0, return sampling cycle 3 of the transaction
    task automatic cargar(input logic [7:0] b);
        datos_MM_in = b;
        dato_valido = 1'b1;
        tick();
        dato_valido = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #3;
        n_cmp++;
        if ({minutos, ack, error_bcd, ocupado, acarreo_HH} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0", {minutos, ack, error_bcd, ocupado, acarreo_HH});
        end
        @(posedge clk);
        #2 reset = 1'b1;
        tick();
    endtask

    task automatic test_carga_valida;
        datos_MM_in = 8'h47;
        dato_valido = 1'b1;
        tick();
        dato_valido = 1'b0;
        n_cmp++;
        if (ocupado !== 1'b1 || ack !== 1'b0) begin
            n_err++;
            $display("FAIL h47_cycle1: got ocupado=%b ack=%b want 1 0", ocupado, ack);
        end
        tick();
        n_cmp++;
        if (ocupado !== 1'b1 || ack !== 1'b0) begin
            n_err++;
            $display("FAIL h47_cycle2: got ocupado=%b ack=%b want 1 0", ocupado, ack);
        end
        tick();
        n_cmp++;
        if (ocupado !== 1'b1 || ack !== 1'b1 || minutos !== 6'd47 || error_bcd !== 1'b0) begin
            n_err++;
            $display("FAIL h47_cycle3: got ocupado=%b ack=%b min=%0d err=%b want 1 1 47 0",
                     ocupado, ack, minutos, error_bcd);
        end
        tick();
        n_cmp++;
        if (ocupado !== 1'b0 || ack !== 1'b0 || minutos !== 6'd47) begin
            n_err++;
            $display("FAIL h47_cycle4: got ocupado=%b ack=%b min=%0d want 0 0 47", ocupado, ack, minutos);
        end
    endtask

    task automatic test_nibble_invalido;
        datos_MM_in = 8'h3A;
        dato_valido = 1'b1;
        tick();
        dato_valido = 1'b0;
        n_cmp++;
        if (ack !== 1'b1 || error_bcd !== 1'b1 || minutos !== 6'd47) begin
            n_err++;
            $display("FAIL h3A_cycle1: got ack=%b err=%b min=%0d want 1 1 47", ack, error_bcd, minutos);
        end
        tick();
        n_cmp++;
        if (ack !== 1'b0 || ocupado !== 1'b0 || error_bcd !== 1'b1 || minutos !== 6'd47) begin
            n_err++;
            $display("FAIL h3A_cycle2: got ack=%b ocup=%b err=%b min=%0d want 0 0 1 47",
                     ack, ocupado, error_bcd, minutos);
        end
        cargar(8'h05);
        n_cmp++;
        if (ack !== 1'b1 || error_bcd !== 1'b0 || minutos !== 6'd5) begin
            n_err++;
            $display("FAIL h05_load: got ack=%b err=%b min=%0d want 1 0 5", ack, error_bcd, minutos);
        end
        tick();
    endtask

    task automatic test_fuera_rango;
        datos_MM_in = 8'h60;
        dato_valido = 1'b1;
        tick();
        dato_valido = 1'b0;
        n_cmp++;
        if (ack !== 1'b0 || error_bcd !== 1'b0) begin
            n_err++;
            $display("FAIL h60_cycle1: got ack=%b err=%b want 0 0", ack, error_bcd);
        end
        tick();
        n_cmp++;
        if (ack !== 1'b1 || error_bcd !== 1'b1 || minutos !== 6'd5) begin
            n_err++;
            $display("FAIL h60_cycle2: got ack=%b err=%b min=%0d want 1 1 5", ack, error_bcd, minutos);
        end
        tick();
        n_cmp++;
        if (ack !== 1'b0 || ocupado !== 1'b0 || error_bcd !== 1'b1 || minutos !== 6'd5) begin
            n_err++;
            $display("FAIL h60_cycle3: got ack=%b ocup=%b err=%b min=%0d want 0 0 1 5",
                     ack, ocupado, error_bcd, minutos);
        end
    endtask

    task automatic test_acarreo;
        logic [5:0] exp_min;
        logic       exp_acc;
        cargar(8'h59);
        n_cmp++;
        if (minutos !== 6'd59 || error_bcd !== 1'b0) begin
            n_err++;
            $display("FAIL h59_load: got min=%0d err=%b want 59 0", minutos, error_bcd);
        end
        tick();
        incremento = 1'b1;
        tick();
        incremento = 1'b0;
`ifdef DECMIN_AUTOINC_EN
        exp_min = 6'd0;
        exp_acc = 1'b1;
`else
        exp_min = 6'd59;
        exp_acc = 1'b0;
`endif
        n_cmp++;
        if (minutos !== exp_min || acarreo_HH !== exp_acc) begin
            n_err++;
            $display("FAIL wrap_inc: got min=%0d acarreo=%b want %0d %b", minutos, acarreo_HH, exp_min, exp_acc);
        end
        tick();
        n_cmp++;
        if (minutos !== exp_min || acarreo_HH !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_after: got min=%0d acarreo=%b want %0d 0", minutos, acarreo_HH, exp_min);
        end
        incremento = 1'b1;
        tick();
        incremento = 1'b0;
`ifdef DECMIN_AUTOINC_EN
        exp_min = 6'd1;
`else
        exp_min = 6'd59;
`endif
        n_cmp++;
        if (minutos !== exp_min || acarreo_HH !== 1'b0) begin
            n_err++;
            $display("FAIL plain_inc: got min=%0d acarreo=%b want %0d 0", minutos, acarreo_HH, exp_min);
        end
    endtask

    task automatic test_inc_en_carga;
        datos_MM_in = 8'h12;
        dato_valido = 1'b1;
        tick();
        datos_MM_in = 8'h34;
        tick();
        dato_valido = 1'b0;
        tick();
        incremento = 1'b1;
        n_cmp++;
        if (ack !== 1'b1 || minutos !== 6'd12) begin
            n_err++;
            $display("FAIL h12_load: got ack=%b min=%0d want 1 12", ack, minutos);
        end
        tick();
        incremento = 1'b0;
        n_cmp++;
        if (minutos !== 6'd12 || acarreo_HH !== 1'b0 || ocupado !== 1'b0) begin
            n_err++;
            $display("FAIL inc_in_carga: got min=%0d acarreo=%b ocup=%b want 12 0 0",
                     minutos, acarreo_HH, ocupado);
        end
        tick();
        n_cmp++;
        if (ocupado !== 1'b0 || ack !== 1'b0 || minutos !== 6'd12) begin
            n_err++;
            $display("FAIL second_strobe_ignored: got ocup=%b ack=%b min=%0d want 0 0 12",
                     ocupado, ack, minutos);
        end
    endtask

    task automatic test_reset_medio;
        int acks;
        datos_MM_in = 8'h30;
        dato_valido = 1'b1;
        tick();
        dato_valido = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (minutos !== 6'd0 || ack !== 1'b0 || error_bcd !== 1'b0 || ocupado !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_async: got min=%0d ack=%b err=%b ocup=%b want 0 0 0 0",
                     minutos, ack, error_bcd, ocupado);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ack !== 1'b0) acks++;
        end
        n_cmp++;
        if (acks != 0 || minutos !== 6'd0 || error_bcd !== 1'b0 || ocupado !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_after: got acks=%0d min=%0d err=%b ocup=%b want 0 0 0 0",
                     acks, minutos, error_bcd, ocupado);
        end
        cargar(8'h21);
        n_cmp++;
        if (ack !== 1'b1 || minutos !== 6'd21) begin
            n_err++;
            $display("FAIL load_after_reset: got ack=%b min=%0d want 1 21", ack, minutos);
        end
        tick();
    endtask

    initial begin
        reset       = 1'b0;
        datos_MM_in = 8'h00;
        dato_valido = 1'b0;
        incremento  = 1'b0;
        test_reset();
        test_carga_valida();
        test_nibble_invalido();
        test_fuera_rango();
        test_acarreo();
        tick();
        test_inc_en_carga();
        test_reset_medio();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
